// File: rtl/clock_pkg.sv
// Shared encodings for the multi-function clock controller:
// mode codes, scheduler states and the blank display pattern.
package clock_pkg;

    localparam logic [1:0] MODE_WATCH = 2'd0;
    localparam logic [1:0] MODE_STP   = 2'd1;
    localparam logic [1:0] MODE_COOK  = 2'd2;

    localparam logic [15:0] BLANK_VALUE = 16'hFFFF;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ALARM  = 2'd1,
        GUARD  = 2'd2
    } state_t;

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return (m == MODE_COOK) ? MODE_WATCH : m + 2'd1;
    endfunction

    function automatic logic [2:0] mode_onehot(input logic [1:0] m);
        return 3'b001 << m;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Enable-gated cycle counter: pulses tc on the last cycle of each
// DIV-cycle period and flips toggle at the end of every period.
module blink_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_p,
    input  logic en,
    input  logic clr,
    output logic toggle,
    output logic tc
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt    <= '0;
            toggle <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            toggle <= 1'b0;
        end else if (en) begin
            if (tc) begin
                cnt    <= '0;
                toggle <= ~toggle;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/mode_scheduler.sv
// Mode owner for the multi-function clock: routes button pulses,
// selects the display value and handles cook-timer alarm pre-emption.
module mode_scheduler
    import clock_pkg::*;
#(
    parameter int BLINK_DIV     = 50_000_000,
    parameter int ALARM_TIMEOUT = 1_500_000_000,
    parameter int GUARD_CYC     = 10_000_000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        mode_btn_pe,
    input  logic [2:0]  func_btn_pe,
    input  logic        alarm_req,
    input  logic [15:0] value_watch,
    input  logic [15:0] value_stp,
    input  logic [15:0] value_cook,
    output logic [1:0]  mode,
    output logic [2:0]  btn_watch,
    output logic [2:0]  btn_stp,
    output logic [2:0]  btn_cook,
    output logic [15:0] value,
    output logic [7:0]  LED_bar,
    output logic        alarm_ack
);

    state_t      st, st_d;
    logic [1:0]  mode_d, prev_mode, prev_d;
    logic        areq_q, pend, pend_d;
    logic        ack_d, rise, press;
    logic [2:0]  bw_d, bs_d, bc_d;
    logic [15:0] val_d;
    logic [7:0]  led_d;

    logic blink_off, blink_tc_unused;
    logic tmo_tc, tmo_tog_unused;
    logic grd_tc, grd_tog_unused;

    blink_timer #(.DIV(BLINK_DIV)) u_blink (
        .clk    (clk),
        .reset_p(reset_p),
        .en     (st == ALARM),
        .clr    (st != ALARM),
        .toggle (blink_off),
        .tc     (blink_tc_unused)
    );

    blink_timer #(.DIV(ALARM_TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset_p(reset_p),
        .en     (st == ALARM),
        .clr    (st != ALARM),
        .toggle (tmo_tog_unused),
        .tc     (tmo_tc)
    );

    blink_timer #(.DIV(GUARD_CYC)) u_guard (
        .clk    (clk),
        .reset_p(reset_p),
        .en     (st == GUARD),
        .clr    (st != GUARD),
        .toggle (grd_tog_unused),
        .tc     (grd_tc)
    );

    assign rise  = alarm_req & ~areq_q;
    assign press = mode_btn_pe | (|func_btn_pe);

    always_comb begin
        st_d   = st;
        mode_d = mode;
        prev_d = prev_mode;
        pend_d = pend;
        ack_d  = 1'b0;
        bw_d   = 3'b000;
        bs_d   = 3'b000;
        bc_d   = 3'b000;
        unique case (st)
            NORMAL: begin
                if (rise || pend) begin
                    prev_d = mode;
                    mode_d = MODE_COOK;
                    st_d   = ALARM;
                    pend_d = 1'b0;
                end else if (mode_btn_pe) begin
                    mode_d = next_mode(mode);
                end else begin
                    unique case (1'b1)
                        (mode == MODE_WATCH): bw_d = func_btn_pe;
                        (mode == MODE_STP):   bs_d = func_btn_pe;
                        default:              bc_d = func_btn_pe;
                    endcase
                end
            end
            ALARM: begin
                // an acknowledge wins over a simultaneous alarm_req fall
                if (press || tmo_tc) begin
                    ack_d  = 1'b1;
                    mode_d = prev_mode;
                    st_d   = GUARD;
                end else if (!alarm_req) begin
                    mode_d = prev_mode;
                    st_d   = GUARD;
                end
            end
            GUARD: begin
                if (rise) pend_d = 1'b1;
                if (grd_tc) st_d = NORMAL;
            end
            default: st_d = NORMAL;
        endcase
    end

    always_comb begin
        val_d = value_watch;
        if (st == ALARM) begin
            val_d = blink_off ? BLANK_VALUE : value_cook;
        end else begin
            unique case (1'b1)
                (mode == MODE_WATCH): val_d = value_watch;
                (mode == MODE_STP):   val_d = value_stp;
                default:              val_d = value_cook;
            endcase
        end
    end

    assign led_d = {st_d == ALARM, st_d == GUARD, 3'b000,
                    mode_onehot(mode_d)};

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            st        <= NORMAL;
            mode      <= MODE_WATCH;
            prev_mode <= MODE_WATCH;
            areq_q    <= 1'b0;
            pend      <= 1'b0;
            btn_watch <= 3'b000;
            btn_stp   <= 3'b000;
            btn_cook  <= 3'b000;
            value     <= 16'h0000;
            LED_bar   <= 8'b0000_0001;
            alarm_ack <= 1'b0;
        end else begin
            st        <= st_d;
            mode      <= mode_d;
            prev_mode <= prev_d;
            areq_q    <= alarm_req;
            pend      <= pend_d;
            btn_watch <= bw_d;
            btn_stp   <= bs_d;
            btn_cook  <= bc_d;
            value     <= val_d;
            LED_bar   <= led_d;
            alarm_ack <= ack_d;
        end
    end

endmodule

// File: tb/tb_mode_scheduler.sv
// Scoreboard bench for mode_scheduler with short blink/timeout/guard
// periods (4 / 20 / 8 cycles).
module tb_mode_scheduler;

    localparam logic [15:0] VW = 16'h1111;
    localparam logic [15:0] VS = 16'h2222;
    localparam logic [15:0] VC = 16'h3333;
    localparam logic [15:0] BL = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        mode_btn_pe;
    logic [2:0]  func_btn_pe;
    logic        alarm_req;
    logic [15:0] value_watch;
    logic [15:0] value_stp;
    logic [15:0] value_cook;
    logic [1:0]  mode;
    logic [2:0]  btn_watch;
    logic [2:0]  btn_stp;
    logic [2:0]  btn_cook;
    logic [15:0] value;
    logic [7:0]  LED_bar;
    logic        alarm_ack;

    typedef struct {
        int          cyc;
        logic [1:0]  m;
        logic [2:0]  bw;
        logic [2:0]  bs;
        logic [2:0]  bc;
        logic [15:0] v;
        logic [7:0]  l;
        logic        a;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    mode_scheduler #(
        .BLINK_DIV    (4),
        .ALARM_TIMEOUT(20),
        .GUARD_CYC    (8)
    ) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .mode_btn_pe(mode_btn_pe),
        .func_btn_pe(func_btn_pe),
        .alarm_req  (alarm_req),
        .value_watch(value_watch),
        .value_stp  (value_stp),
        .value_cook (value_cook),
        .mode       (mode),
        .btn_watch  (btn_watch),
        .btn_stp    (btn_stp),
        .btn_cook   (btn_cook),
        .value      (value),
        .LED_bar    (LED_bar),
        .alarm_ack  (alarm_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] blink(input int k);
        return (((k - 1) / 4) % 2 == 0) ? VC : BL;
    endfunction

    task automatic push(input string tag, input logic [1:0] m,
                        input logic [2:0] bw, input logic [2:0] bs,
                        input logic [2:0] bc, input logic [15:0] v,
                        input logic [7:0] l, input logic a);
        exp_t e;
        e.cyc = cyc + 1;
        e.m   = m;
        e.bw  = bw;
        e.bs  = bs;
        e.bc  = bc;
        e.v   = v;
        e.l   = l;
        e.a   = a;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    // advance one clock, then retire every scoreboard entry now due
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            total++;
            if (e.cyc != cyc ||
                {mode, btn_watch, btn_stp, btn_cook, value, LED_bar, alarm_ack}
                !== {e.m, e.bw, e.bs, e.bc, e.v, e.l, e.a}) begin
                bad++;
                $display("FAIL %s cyc=%0d got m=%0d bw=%b bs=%b bc=%b v=%h led=%b ack=%b want m=%0d bw=%b bs=%b bc=%b v=%h led=%b ack=%b",
                         e.tag, cyc, mode, btn_watch, btn_stp, btn_cook,
                         value, LED_bar, alarm_ack, e.m, e.bw, e.bs, e.bc,
                         e.v, e.l, e.a);
            end
        end
    endtask

    task automatic test_reset();
        reset_p     = 1'b1;
        mode_btn_pe = 1'b0;
        func_btn_pe = 3'b000;
        alarm_req   = 1'b0;
        value_watch = VW;
        value_stp   = VS;
        value_cook  = VC;
        tick();
        tick();
        total++;
        if ({mode, btn_watch, btn_stp, btn_cook, value, LED_bar, alarm_ack}
            !== {2'd0, 9'd0, 16'h0000, 8'h01, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got m=%0d v=%h led=%b ack=%b want m=0 v=0000 led=00000001 ack=0",
                     mode, value, LED_bar, alarm_ack);
        end
        reset_p = 1'b0;
        push("post_reset", 0, 0, 0, 0, VW, 8'h01, 0);
        tick();
    endtask

    task automatic test_mode_cycle();
        logic [15:0] vals [3];
        logic [7:0]  leds [3];
        vals = '{VW, VS, VC};
        leds = '{8'h01, 8'h02, 8'h04};
        for (int i = 0; i < 3; i++) begin
            mode_btn_pe = 1'b1;
            push("mode_step", 2'((i + 1) % 3), 0, 0, 0, vals[i],
                 leds[(i + 1) % 3], 0);
            tick();
            mode_btn_pe = 1'b0;
            push("mode_value", 2'((i + 1) % 3), 0, 0, 0,
                 vals[(i + 1) % 3], leds[(i + 1) % 3], 0);
            tick();
        end
    endtask

    task automatic test_routing();
        func_btn_pe = 3'b100;
        push("route_watch", 0, 3'b100, 0, 0, VW, 8'h01, 0);
        tick();
        func_btn_pe = 3'b000;
        mode_btn_pe = 1'b1;
        push("to_stp", 1, 0, 0, 0, VW, 8'h02, 0);
        tick();
        mode_btn_pe = 1'b0;
        push("stp_idle", 1, 0, 0, 0, VS, 8'h02, 0);
        tick();
        func_btn_pe = 3'b010;
        push("route_stp", 1, 0, 3'b010, 0, VS, 8'h02, 0);
        tick();
        func_btn_pe = 3'b000;
        push("route_stp_end", 1, 0, 0, 0, VS, 8'h02, 0);
        tick();
        func_btn_pe = 3'b101;
        mode_btn_pe = 1'b1;
        push("mode_wins", 2, 0, 0, 0, VS, 8'h04, 0);
        tick();
        func_btn_pe = 3'b000;
        mode_btn_pe = 1'b0;
        push("cook_idle", 2, 0, 0, 0, VC, 8'h04, 0);
        tick();
        func_btn_pe = 3'b001;
        push("route_cook", 2, 0, 0, 3'b001, VC, 8'h04, 0);
        tick();
        func_btn_pe = 3'b000;
        mode_btn_pe = 1'b1;
        push("wrap_watch", 0, 0, 0, 0, VC, 8'h01, 0);
        tick();
        mode_btn_pe = 1'b0;
        push("watch_idle", 0, 0, 0, 0, VW, 8'h01, 0);
        tick();
    endtask

    task automatic test_alarm_press();
        alarm_req   = 1'b1;
        func_btn_pe = 3'b010;
        push("alarm_entry", 2, 0, 0, 0, VW, 8'h84, 0);
        tick();
        func_btn_pe = 3'b000;
        for (int k = 1; k <= 10; k++) begin
            push("alarm_blink", 2, 0, 0, 0, blink(k), 8'h84, 0);
            tick();
        end
        func_btn_pe = 3'b001;
        push("alarm_ack", 0, 0, 0, 0, blink(11), 8'h41, 1);
        tick();
        for (int j = 1; j <= 9; j++) begin
            if (j == 1) alarm_req = 1'b0;
            push("guard_drop", 0, (j == 9) ? 3'b001 : 3'b000, 0, 0, VW,
                 (j <= 7) ? 8'h41 : 8'h01, 0);
            tick();
        end
        func_btn_pe = 3'b000;
    endtask

    task automatic test_timeout();
        mode_btn_pe = 1'b1;
        push("to_stp2", 1, 0, 0, 0, VW, 8'h02, 0);
        tick();
        mode_btn_pe = 1'b0;
        push("stp_idle2", 1, 0, 0, 0, VS, 8'h02, 0);
        tick();
        alarm_req = 1'b1;
        push("tmo_entry", 2, 0, 0, 0, VS, 8'h84, 0);
        tick();
        for (int k = 1; k <= 19; k++) begin
            push("tmo_wait", 2, 0, 0, 0, blink(k), 8'h84, 0);
            tick();
        end
        push("tmo_ack", 1, 0, 0, 0, blink(20), 8'h42, 1);
        tick();
        for (int j = 1; j <= 9; j++) begin
            if (j == 3) alarm_req = 1'b0;
            if (j == 4) alarm_req = 1'b1;
            if (j <= 7)
                push("tmo_guard", 1, 0, 0, 0, VS, 8'h42, 0);
            else if (j == 8)
                push("guard_exit", 1, 0, 0, 0, VS, 8'h02, 0);
            else
                push("latched_alarm", 2, 0, 0, 0, VS, 8'h84, 0);
            tick();
        end
    endtask

    task automatic test_alarm_drop();
        push("drop_blink", 2, 0, 0, 0, VC, 8'h84, 0);
        tick();
        alarm_req = 1'b0;
        push("drop_restore", 1, 0, 0, 0, VC, 8'h42, 0);
        tick();
        for (int g = 1; g <= 8; g++) begin
            func_btn_pe = (g == 5) ? 3'b010 : 3'b000;
            push("drop_guard", 1, 0, 0, 0, VS, (g <= 7) ? 8'h42 : 8'h02, 0);
            tick();
        end
        func_btn_pe = 3'b010;
        push("drop_route", 1, 0, 3'b010, 0, VS, 8'h02, 0);
        tick();
        func_btn_pe = 3'b000;
    endtask

    task automatic test_reset_mid_alarm();
        alarm_req = 1'b1;
        push("rst_entry", 2, 0, 0, 0, VS, 8'h84, 0);
        tick();
        push("rst_blink", 2, 0, 0, 0, VC, 8'h84, 0);
        tick();
        #3;
        func_btn_pe = 3'b001;
        reset_p     = 1'b1;
        #1;
        total++;
        if ({mode, btn_watch, btn_stp, btn_cook, value, LED_bar, alarm_ack}
            !== {2'd0, 9'd0, 16'h0000, 8'h01, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got m=%0d v=%h led=%b ack=%b want m=0 v=0000 led=00000001 ack=0",
                     mode, value, LED_bar, alarm_ack);
        end
        tick();
        total++;
        if (alarm_ack !== 1'b0 || mode !== 2'd0 || LED_bar !== 8'h01) begin
            bad++;
            $display("FAIL reset_hold got m=%0d led=%b ack=%b want m=0 led=00000001 ack=0",
                     mode, LED_bar, alarm_ack);
        end
        alarm_req   = 1'b0;
        func_btn_pe = 3'b000;
        reset_p     = 1'b0;
        push("after_rst", 0, 0, 0, 0, VW, 8'h01, 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_routing();
        test_alarm_press();
        test_timeout();
        test_alarm_drop();
        test_reset_mid_alarm();
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover got %0d entries want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
